data_mem_responder: RTL and testbench

- Memory-side responder for the core's M-stage data port: it receives the core's load/store requests and returns read data.
- Holds a word-addressed RAM and inserts a configurable number of wait states.
- Asserts a stall toward the hazard logic for the full duration of each access.
- Flags misaligned or out-of-range accesses as faults; a faulting access never modifies memory.

---
 rtl/data_mem_responder.sv | 115 +++++++++++
 tb/tb_data_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-side memory responder for the M stage: word RAM behind a fixed number of
// wait states, with stall toward hazard logic and fault reporting on bad addresses.
module data_mem_responder #(
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_stall,
   output logic                  mem_done,
   output logic                  mem_fault
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state;
   state_t                  nextState;
   logic [CNT_W-1:0]        cnt;
   logic                    weQ;
   logic [ADDR_WIDTH-1:0]   addrQ;
   logic [DATA_WIDTH-1:0]   wdataQ;
   logic [DATA_WIDTH-1:0]   ram [DEPTH_WORDS];

   logic                    accWe;
   logic [ADDR_WIDTH-1:0]   accAddr;
   logic [DATA_WIDTH-1:0]   accWdata;
   logic                    accFault;
   logic [IDX_W-1:0]        accIdx;
   logic                    enterResp;
   logic                    ramWe;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (mem_req) nextState = (WAIT_CYCLES > 0) ? WAIT : RESP;
         WAIT:    if (cnt == CNT_W'(1)) nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // With zero wait states the access resolves at the sampling edge, so the live inputs are used.
   always_comb begin
      mem_stall = mem_req && (state != RESP);
      accWe     = weQ;
      accAddr   = addrQ;
      accWdata  = wdataQ;
      if (state == IDLE) begin
         accWe    = mem_we;
         accAddr  = mem_addr;
         accWdata = mem_wdata;
      end
      accFault  = (accAddr[1:0] != 2'b00) || (accAddr >= ADDR_LIMIT);
      accIdx    = accAddr[IDX_W+1:2];
      enterResp = (nextState == RESP) && (state != RESP);
      ramWe     = enterResp && accWe && !accFault;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         weQ       <= 1'b0;
         addrQ     <= '0;
         wdataQ    <= '0;
         mem_rdata <= '0;
         mem_done  <= 1'b0;
         mem_fault <= 1'b0;
      end else begin
         if ((state == IDLE) && mem_req) begin
            cnt    <= CNT_W'(WAIT_CYCLES);
            weQ    <= mem_we;
            addrQ  <= mem_addr;
            wdataQ <= mem_wdata;
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (enterResp && !accWe) begin
            mem_rdata <= accFault ? '0 : ram[accIdx];
         end
         mem_done  <= enterResp;
         mem_fault <= enterResp && accFault;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (ramWe) begin
         ram[accIdx] <= accWdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with two wait states and
// one with none, driven by directed and random accesses against an array model.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 256;

   typedef struct {
      bit          isStore;
      bit          fault;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstN  [2];
   logic        req   [2];
   logic        we    [2];
   logic [63:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        stall [2];
   logic        done  [2];
   logic        fault [2];

   int          vectors = 0;
   int          miscompares = 0;
   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] model [2][DEPTH];
   bit          known [2][DEPTH];
   logic [31:0] lastRd [2];
   int          stallCnt [2];

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut0 (
      .clk(clk), .reset(rstN[0]), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
      .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_stall(stall[0]), .mem_done(done[0]),
      .mem_fault(fault[0]));

   data_mem_responder #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .reset(rstN[1]), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
      .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_stall(stall[1]), .mem_done(done[1]),
      .mem_fault(fault[1]));

   function automatic int waitsOf(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Monitor: pops the oldest expectation whenever an instance reports completion.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rstN[i] !== 1'b1) begin
            stallCnt[i] = 0;
         end else begin
            if (stall[i] === 1'b1) stallCnt[i]++;
            if (done[i] === 1'b1) begin
               exp_t e;
               bit   have;
               have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
               if (!have) begin
                  chk($sformatf("unexpected_done%0d", i), 64'd1, 64'd0);
               end else begin
                  if (i == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  chk($sformatf("fault%0d", i), 64'(fault[i]), 64'(e.fault));
                  chk($sformatf("rdata%0d", i), 64'(rdata[i]), 64'(e.rdata));
                  chk($sformatf("stall_cycles%0d", i), 64'(stallCnt[i]), 64'(waitsOf(i) + 1));
               end
               stallCnt[i] = 0;
            end else begin
               chk($sformatf("fault_idle%0d", i), 64'(fault[i]), 64'd0);
            end
         end
      end
   end

   // Issue one access, predicting its outcome from the address rules and the model array.
   task automatic access(input int i, input bit isStore, input logic [63:0] a,
                         input logic [31:0] d, input bit scramble);
      exp_t e;
      bit   f;
      int   cyc;
      f = ((a % 4) != 0) || (a >= 64'(DEPTH * 4));
      e.isStore = isStore;
      e.fault   = f;
      if (isStore) begin
         if (!f) begin
            model[i][int'(a / 4)] = d;
            known[i][int'(a / 4)] = 1'b1;
         end
         e.rdata = lastRd[i];
      end else begin
         e.rdata   = f ? 32'd0 : model[i][int'(a / 4)];
         lastRd[i] = e.rdata;
      end
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
      req[i]   = 1'b1;
      we[i]    = isStore;
      addr[i]  = a;
      wdata[i] = d;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (scramble && cyc == 1) begin
            addr[i]  = {$urandom, $urandom};
            wdata[i] = $urandom;
            we[i]    = ~we[i];
         end
      end while (done[i] !== 1'b1 && cyc < 40);
      if (done[i] !== 1'b1) chk($sformatf("done_timeout%0d", i), 64'd0, 64'd1);
      req[i] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic randomOps(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         int          kind;
         int          w;
         bit          st;
         logic [63:0] a;
         kind = $urandom_range(0, 9);
         st   = 1'($urandom_range(0, 1));
         w    = $urandom_range(0, DEPTH - 1);
         case (kind)
            0:       a = 64'(w * 4 + $urandom_range(1, 3));
            1:       a = 64'(w * 4) | (64'($urandom_range(1, 255)) << 32);
            2:       a = 64'(DEPTH * 4 + w * 4);
            default: begin
               if (!st) while (!known[i][w]) w = (w + 1) % DEPTH;
               a = 64'(w * 4);
            end
         endcase
         access(i, st, a, $urandom, (waitsOf(i) > 0) && ($urandom_range(0, 1) == 1));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rstN[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
         addr[i] = '0; wdata[i] = '0; lastRd[i] = '0; stallCnt[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset_rdata%0d", i), 64'(rdata[i]), 64'd0);
         chk($sformatf("reset_done%0d", i), 64'(done[i]), 64'd0);
         chk($sformatf("reset_fault%0d", i), 64'(fault[i]), 64'd0);
         chk($sformatf("reset_stall%0d", i), 64'(stall[i]), 64'd0);
      end
      req[0] = 1'b1; #1;
      chk("reset_stall_follows_req", 64'(stall[0]), 64'd1);
      req[0] = 1'b0;
      @(posedge clk); #1;
      rstN[0] = 1'b1; rstN[1] = 1'b1;
      @(posedge clk); #1;

      access(0, 1'b1, 64'h0,  32'h1357_9BDF, 1'b0);
      access(0, 1'b1, 64'h40, 32'hDEAD_BEEF, 1'b0);
      access(0, 1'b0, 64'h40, 32'h0, 1'b0);
      access(0, 1'b1, 64'h41, 32'hFFFF_FFFF, 1'b0);
      access(0, 1'b0, 64'h40, 32'h0, 1'b0);
      access(0, 1'b0, 64'h0000_0001_0000_0000, 32'h0, 1'b0);
      access(0, 1'b1, 64'h80, 32'h0BAD_F00D, 1'b0);
      access(0, 1'b1, 64'hC0, 32'h600D_CAFE, 1'b1);
      access(0, 1'b0, 64'hC0, 32'h0, 1'b1);

      // Abort a store in its wait phase; the write must never land.
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 64'h80; wdata[0] = 32'hAAAA_5555;
      @(posedge clk); #1;
      rstN[0] = 1'b0; lastRd[0] = '0;
      #1;
      chk("midreset_stall", 64'(stall[0]), 64'd1);
      chk("midreset_rdata", 64'(rdata[0]), 64'd0);
      chk("midreset_done", 64'(done[0]), 64'd0);
      req[0] = 1'b0;
      #1;
      chk("midreset_stall_idle", 64'(stall[0]), 64'd0);
      @(posedge clk); #1;
      rstN[0] = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      access(0, 1'b0, 64'h80, 32'h0, 1'b0);

      access(1, 1'b1, 64'h0, 32'h1234_5678, 1'b0);
      access(1, 1'b0, 64'h0, 32'h0, 1'b0);
      access(1, 1'b1, 64'h41, 32'hFFFF_FFFF, 1'b0);
      access(1, 1'b0, 64'h0000_0001_0000_0000, 32'h0, 1'b0);
      access(1, 1'b0, 64'h0, 32'h0, 1'b0);

      randomOps(0, 40);
      randomOps(1, 40);

      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("pending_expect0", 64'(q0.size()), 64'd0);
      chk("pending_expect1", 64'(q1.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
